issue_window: RTL and testbench
===============================

# issue_window

Buffered N-wide in-order issue stage between decode and execute. It generalises the fixed dual-issue check to ISSUE_W lanes. It adds a BUF_DEPTH instruction FIFO with valid/ready handshakes on both sides and a register scoreboard for long-latency writers (LSU/MUL/DIV), and issues the longest hazard-free prefix of the FIFO head each cycle.

## Interface
Parameters:
- ISSUE_W, 2, lanes accepted and issued per cycle (1..4)
- BUF_DEPTH, 8, FIFO entries; power of two, ≥ 2*ISSUE_W
- WB_PORTS, 2, scoreboard clear ports

Ports:
- clk  in  1  clock; everything on rising edge
- rst  in  1  synchronous, active-high reset
- d_inst_i  in  ISSUE_W x inst_t  decoded instructions, lane 0 oldest
- d_valid_i  in  ISSUE_W  prefix mask (0…01…1 form)
- d_ready_o  out  1  buffer has ≥ ISSUE_W free entries and rst low
- flush_i  in  1  discard all buffered instructions
- wb_valid_i  in  WB_PORTS  late writeback strobes
- wb_reg_i  in  WB_PORTS x 5  register written back
- ex_ready_i  in  1  execute accepts the group
- ex_valid_o  out  1  equals is_o[0]
- ex_inst_o  out  ISSUE_W x inst_t  FIFO head entries, lane k = head+k
- is_o  out  ISSUE_W  issue prefix mask

## Operation
- Enqueue when `d_ready_o && d_valid_i[0] && !flush_i`. popcount(d_valid_i) entries are written at the tail in lane order.
- Issue window: entries head..head+ISSUE_W-1 that hold valid data.
- Lane k is issuable when all of the following hold:
  - The entry is valid and lanes 0..k-1 are issuable.
  - No source r_reg[0/1] and no w_reg is busy in the scoreboard. r0 is never busy.
  - No RAW against any earlier lane j<k: w_reg[j]≠0 and w_reg[j] equals r_reg[0] or r_reg[1] of lane k.
  - No WAW against any earlier lane: equal non-zero w_reg.
  - No earlier lane shares need_mul, need_div, need_lsu or need_bpu with lane k.
  - need_csr issues only in lane 0 and blocks all later lanes.
- is_o is the issuable prefix. is_o is forced to 0 in a flush cycle.
- Transfer happens on `ex_valid_o && ex_ready_i`:
  - head advances by popcount(is_o).
  - For each issued lane with (need_lsu|need_mul|need_div) and w_reg≠0, busy[w_reg] is set.
- A wb_valid_i on port p clears busy[wb_reg_i[p]]. A set and a clear of the same register in one cycle: the set wins.
- flush_i empties the FIFO (head=tail, count=0) and takes priority over enqueue. The scoreboard is untouched because in-flight ops still write back.
- Pointers wrap modulo BUF_DEPTH. count is $clog2(BUF_DEPTH+1) bits. Enqueue and issue in the same cycle update count by (enq − iss).

## Timing
- Reset values:
  - FIFO empty, all busy bits 0.
  - ex_valid_o=0, is_o=0.
  - d_ready_o=0 while rst is high, 1 on the first cycle after reset.
- Latency: an entry enqueued at edge t can be issued in cycle t+1 at the earliest. There is no input-to-output bypass.
- ex_valid_o, is_o and ex_inst_o are combinational from registered state, wb_* (see Configuration) and flush_i. They never depend on ex_ready_i.
- While stalled (valid high, ready low), is_o never shrinks except on flush. It may grow as busy bits clear.
- Full: d_ready_o drops when free entries < ISSUE_W, even if the incoming group is smaller.
- Empty: is_o=0.
- Reset mid-operation discards buffer and scoreboard next edge.

## Configuration
- ISSUE_SB_BYPASS_EN defined: a wb_valid_i for register r in cycle t masks busy[r] in the issue check in cycle t, so a consumer can issue the same cycle.
- ISSUE_SB_BYPASS_EN undefined: the issue check uses registered busy bits only, so the consumer issues at t+1 at the earliest. This removes the wb-to-ex_valid_o combinational path.

## Structure
- pipeline.svh gains late_wb(inst_t) helper logic, the ISSUE_W/BUF_DEPTH defaults, and typedef issue_mask_t. inst_t is unchanged.
- Sub-module issue_scoreboard holds the 32 busy bits, the set/clear ports and the bypassed busy vector output. FIFO and hazard logic stay in issue_window.

## Test plan
- ISSUE_W=2: lane0 add r3←r1, lane1 sub r5←r3 -> is_o=01. Next cycle the sub issues alone, is_o=01.
- ISSUE_W=4: add, ld r7, mul, div with distinct regs -> is_o=1111.
  - Then add r8←r7 -> stalls, is_o=0, until wb_valid_i[0]=1, wb_reg_i=7.
  - Issue cycle: same cycle with the macro, next cycle without.
- Two loads in lanes 0/1 -> is_o=01. A csr in lane 1 -> is_o=01, then the csr issues alone.
- Fill BUF_DEPTH=8 with ex_ready_i=0 -> d_ready_o drops at count 7 (ISSUE_W=2). Release -> pointers wrap and instruction order is preserved.
- flush_i with 5 entries buffered and an enqueue in the same cycle -> count=0, is_o=0, enqueue dropped, busy bits unchanged.
- Stall with ld r4 busy, then set r4 and clear r4 in the same cycle -> r4 stays busy.

Source files
------------

// File: rtl/issue_window_pkg.sv
// issue_window_pkg: shared types and helpers for the buffered in-order issue stage.
// The optional macro ISSUE_SB_BYPASS_EN is consumed by issue_scoreboard.
package issue_window_pkg;

  localparam int ISSUE_W_DEF   = 2;
  localparam int BUF_DEPTH_DEF = 8;
  localparam int WB_PORTS_DEF  = 2;
  localparam int NUM_REGS      = 32;

  // Decoded instruction as delivered by decode; tag is an opaque payload.
  typedef struct packed {
    logic [15:0]     tag;
    logic [1:0][4:0] r_reg;
    logic [4:0]      w_reg;
    logic            need_mul;
    logic            need_div;
    logic            need_lsu;
    logic            need_bpu;
    logic            need_csr;
  } inst_t;

  typedef logic [ISSUE_W_DEF-1:0] issue_mask_t;

  // Long-latency writer whose destination must be tracked until writeback.
  function automatic logic late_wb(input inst_t inst);
    return (inst.need_lsu | inst.need_mul | inst.need_div) && (inst.w_reg != 5'd0);
  endfunction

  // Two instructions competing for the same single-instance execution unit.
  function automatic logic shares_unit(input inst_t a, input inst_t b);
    return (a.need_mul & b.need_mul) | (a.need_div & b.need_div) |
           (a.need_lsu & b.need_lsu) | (a.need_bpu & b.need_bpu);
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: 32 busy bits for registers awaiting a late writeback.
// Set on issue of a long-latency writer, cleared by writeback; set wins.
// ISSUE_SB_BYPASS_EN: when defined, same-cycle writebacks are masked out of busy_o.
module issue_scoreboard
  import issue_window_pkg::*;
#(
  parameter int SET_PORTS = 2,
  parameter int WB_PORTS  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SET_PORTS-1:0]      set_valid_i,
  input  logic [SET_PORTS-1:0][4:0] set_reg_i,
  input  logic [WB_PORTS-1:0]       clr_valid_i,
  input  logic [WB_PORTS-1:0][4:0]  clr_reg_i,
  output logic [NUM_REGS-1:0]       busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;

  // Decode set/clear ports into masks and form the next busy vector.
  always_comb begin
    set_mask_s = '0;
    clr_mask_s = '0;
    for (int p = 0; p < SET_PORTS; p++) begin
      set_mask_s[set_reg_i[p]] = set_mask_s[set_reg_i[p]] | set_valid_i[p];
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      clr_mask_s[clr_reg_i[p]] = clr_mask_s[clr_reg_i[p]] | clr_valid_i[p];
    end
    busy_d    = (busy_q & ~clr_mask_s) | set_mask_s;
    busy_d[0] = 1'b0;
  end

  // Busy bit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Busy vector seen by the issue check.
`ifdef ISSUE_SB_BYPASS_EN
  always_comb begin
    busy_o = busy_q & ~clr_mask_s;
  end
`else
  always_comb begin
    busy_o = busy_q;
  end
`endif

endmodule

// File: rtl/issue_window.sv
// issue_window: BUF_DEPTH-entry instruction FIFO feeding an ISSUE_W-wide in-order
// issue check; each cycle the longest hazard-free prefix at the head is offered.
// Optional macro ISSUE_SB_BYPASS_EN lets a same-cycle writeback unblock a consumer.
module issue_window
  import issue_window_pkg::*;
#(
  parameter int ISSUE_W   = ISSUE_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int WB_PORTS  = WB_PORTS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  inst_t [ISSUE_W-1:0]      d_inst_i,
  input  logic [ISSUE_W-1:0]       d_valid_i,
  output logic                     d_ready_o,
  input  logic                     flush_i,
  input  logic [WB_PORTS-1:0]      wb_valid_i,
  input  logic [WB_PORTS-1:0][4:0] wb_reg_i,
  input  logic                     ex_ready_i,
  output logic                     ex_valid_o,
  output inst_t [ISSUE_W-1:0]      ex_inst_o,
  output logic [ISSUE_W-1:0]       is_o
);

  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int LANE_W = $clog2(ISSUE_W + 1);

  inst_t            mem_q [BUF_DEPTH];
  inst_t            mem_d [BUF_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [NUM_REGS-1:0]     busy_s;
  logic [ISSUE_W-1:0]      is_raw_s;
  logic                    prev_ok_s;
  logic                    haz_s;
  logic                    enq_s;
  logic                    xfer_s;
  logic [LANE_W-1:0]       enq_n_s;
  logic [LANE_W-1:0]       iss_n_s;
  logic [PTR_W-1:0]        rd_idx_s;
  logic [PTR_W-1:0]        wr_idx_s;
  logic [ISSUE_W-1:0]      set_valid_s;
  logic [ISSUE_W-1:0][4:0] set_reg_s;

  function automatic logic [LANE_W-1:0] popcnt(input logic [ISSUE_W-1:0] m);
    logic [LANE_W-1:0] n;
    n = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      n = n + LANE_W'(m[i]);
    end
    return n;
  endfunction

  issue_scoreboard #(
    .SET_PORTS (ISSUE_W),
    .WB_PORTS  (WB_PORTS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_valid_i (set_valid_s),
    .set_reg_i   (set_reg_s),
    .clr_valid_i (wb_valid_i),
    .clr_reg_i   (wb_reg_i),
    .busy_o      (busy_s)
  );

  // Accept a group only with room for a full-width group and outside reset.
  always_comb begin
    d_ready_o = !rst && ((CNT_W'(BUF_DEPTH) - count_q) >= CNT_W'(ISSUE_W));
  end

  // Present the issue window: lane k shows entry head+k.
  always_comb begin
    rd_idx_s  = head_q;
    ex_inst_o = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      rd_idx_s     = head_q + PTR_W'(k);
      ex_inst_o[k] = mem_q[rd_idx_s];
    end
  end

  // Hazard check: a lane issues only if valid, hazard-free and all older lanes issue.
  always_comb begin
    is_raw_s  = '0;
    prev_ok_s = 1'b1;
    haz_s     = 1'b0;
    for (int k = 0; k < ISSUE_W; k++) begin
      haz_s = busy_s[ex_inst_o[k].r_reg[0]] | busy_s[ex_inst_o[k].r_reg[1]] |
              busy_s[ex_inst_o[k].w_reg];
      haz_s = haz_s | ((k != 0) && (ex_inst_o[k].need_csr || ex_inst_o[0].need_csr));
      for (int j = 0; j < k; j++) begin
        haz_s = haz_s |
                ((ex_inst_o[j].w_reg != 5'd0) &&
                 ((ex_inst_o[j].w_reg == ex_inst_o[k].r_reg[0]) ||
                  (ex_inst_o[j].w_reg == ex_inst_o[k].r_reg[1]) ||
                  (ex_inst_o[j].w_reg == ex_inst_o[k].w_reg))) |
                shares_unit(ex_inst_o[j], ex_inst_o[k]);
      end
      is_raw_s[k] = prev_ok_s & (count_q > CNT_W'(k)) & ~haz_s;
      prev_ok_s   = is_raw_s[k];
    end
    if (flush_i) begin
      is_o = '0;
    end else begin
      is_o = is_raw_s;
    end
    ex_valid_o = is_o[0];
  end

  // Handshake decode: enqueue/issue amounts and scoreboard set requests.
  always_comb begin
    enq_s  = d_ready_o & d_valid_i[0] & ~flush_i;
    xfer_s = ex_valid_o & ex_ready_i;
    if (enq_s) begin
      enq_n_s = popcnt(d_valid_i);
    end else begin
      enq_n_s = '0;
    end
    if (xfer_s) begin
      iss_n_s = popcnt(is_o);
    end else begin
      iss_n_s = '0;
    end
    for (int k = 0; k < ISSUE_W; k++) begin
      set_valid_s[k] = xfer_s & is_o[k] & late_wb(ex_inst_o[k]);
      set_reg_s[k]   = ex_inst_o[k].w_reg;
    end
  end

  // Next FIFO contents and pointers; flush wins over enqueue.
  always_comb begin
    mem_d    = mem_q;
    wr_idx_s = tail_q;
    for (int k = 0; k < ISSUE_W; k++) begin
      wr_idx_s = tail_q + PTR_W'(k);
      if (enq_s && d_valid_i[k]) begin
        mem_d[wr_idx_s] = d_inst_i[k];
      end else begin
        mem_d[wr_idx_s] = mem_q[wr_idx_s];
      end
    end
    if (flush_i) begin
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(iss_n_s);
      tail_d  = tail_q + PTR_W'(enq_n_s);
      count_d = count_q + CNT_W'(enq_n_s) - CNT_W'(iss_n_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_issue_window.sv
`timescale 1ns/1ps
module tb_issue_window;
  import issue_window_pkg::*;

`ifdef ISSUE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_MUL  = 5'b10000;
  localparam logic [4:0] F_DIV  = 5'b01000;
  localparam logic [4:0] F_LSU  = 5'b00100;
  localparam logic [4:0] F_BPU  = 5'b00010;
  localparam logic [4:0] F_CSR  = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int failures = 0;

  // ISSUE_W=2 instance (a_*) and ISSUE_W=4 instance (b_*)
  inst_t [1:0]      a_inst, a_exi;
  logic [1:0]       a_valid, a_is, a_wbv;
  logic [1:0][4:0]  a_wbr;
  logic             a_ready, a_flush, a_exr, a_exv;
  inst_t [3:0]      b_inst, b_exi;
  logic [3:0]       b_valid, b_is;
  logic [1:0]       b_wbv;
  logic [1:0][4:0]  b_wbr;
  logic             b_ready, b_flush, b_exr, b_exv;

  issue_window #(.ISSUE_W(2), .BUF_DEPTH(8), .WB_PORTS(2)) u2 (
    .clk(clk), .rst(rst), .d_inst_i(a_inst), .d_valid_i(a_valid), .d_ready_o(a_ready),
    .flush_i(a_flush), .wb_valid_i(a_wbv), .wb_reg_i(a_wbr), .ex_ready_i(a_exr),
    .ex_valid_o(a_exv), .ex_inst_o(a_exi), .is_o(a_is));

  issue_window #(.ISSUE_W(4), .BUF_DEPTH(8), .WB_PORTS(2)) u4 (
    .clk(clk), .rst(rst), .d_inst_i(b_inst), .d_valid_i(b_valid), .d_ready_o(b_ready),
    .flush_i(b_flush), .wb_valid_i(b_wbv), .wb_reg_i(b_wbr), .ex_ready_i(b_exr),
    .ex_valid_o(b_exv), .ex_inst_o(b_exi), .is_o(b_is));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic inst_t mk(input int tag, input int rd, input int rs0, input int rs1,
                               input logic [4:0] fl);
    inst_t i;
    i.tag      = 16'(tag);
    i.w_reg    = 5'(rd);
    i.r_reg[0] = 5'(rs0);
    i.r_reg[1] = 5'(rs1);
    {i.need_mul, i.need_div, i.need_lsu, i.need_bpu, i.need_csr} = fl;
    return i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_inst = '0; a_valid = '0; a_flush = 1'b0; a_wbv = '0; a_wbr = '0; a_exr = 1'b0;
    b_inst = '0; b_valid = '0; b_flush = 1'b0; b_wbv = '0; b_wbr = '0; b_exr = 1'b0;
  endtask

  // ---------------- reference model (ISSUE_W=4 instance) ----------------
  inst_t mq[$];
  bit    mbusy[32];
  bit    eff[32];

  function automatic bit can_issue(input int k);
    inst_t c;
    inst_t p;
    c = mq[k];
    if (eff[c.r_reg[0]] || eff[c.r_reg[1]] || eff[c.w_reg]) return 1'b0;
    if (k != 0 && (c.need_csr || mq[0].need_csr)) return 1'b0;
    for (int j = 0; j < k; j++) begin
      p = mq[j];
      if (p.w_reg != 0 && (p.w_reg == c.r_reg[0] || p.w_reg == c.r_reg[1])) return 1'b0;
      if (p.w_reg != 0 && p.w_reg == c.w_reg) return 1'b0;
      if ((p.need_mul && c.need_mul) || (p.need_div && c.need_div) ||
          (p.need_lsu && c.need_lsu) || (p.need_bpu && c.need_bpu)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic inst_t rnd_inst(input int tag);
    logic [4:0] fl;
    fl = {($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0)};
    return mk(tag, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), fl);
  endfunction

  typedef struct packed {
    inst_t [3:0] g;
    logic  [3:0] exp_is;
  } vec_t;

  vec_t vt[10];
  int   got[$];

  initial begin
    // ---------------- table of single-group hazard vectors ----------------
    vt[0] = '{g: {mk(4,10,5,0,F_DIV), mk(3,9,4,0,F_MUL), mk(2,7,2,0,F_LSU), mk(1,3,1,2,F_NONE)}, exp_is: 4'b1111};
    vt[1] = '{g: {mk(4,6,1,0,F_NONE), mk(3,4,1,0,F_NONE), mk(2,5,3,0,F_NONE), mk(1,3,1,2,F_NONE)}, exp_is: 4'b0001};
    vt[2] = '{g: {mk(4,8,1,0,F_NONE), mk(3,3,6,0,F_NONE), mk(2,4,1,2,F_NONE), mk(1,3,1,2,F_NONE)}, exp_is: 4'b0011};
    vt[3] = '{g: {mk(4,6,1,0,F_NONE), mk(3,5,1,0,F_NONE), mk(2,4,1,0,F_LSU), mk(1,3,1,0,F_LSU)}, exp_is: 4'b0001};
    vt[4] = '{g: {mk(4,6,1,0,F_NONE), mk(3,5,1,0,F_NONE), mk(2,4,1,0,F_CSR), mk(1,3,1,0,F_NONE)}, exp_is: 4'b0001};
    vt[5] = '{g: {mk(4,6,1,0,F_NONE), mk(3,5,1,0,F_NONE), mk(2,4,1,0,F_NONE), mk(1,3,1,0,F_CSR)}, exp_is: 4'b0001};
    vt[6] = '{g: {mk(4,0,0,1,F_NONE), mk(3,5,0,0,F_NONE), mk(2,0,0,0,F_NONE), mk(1,0,1,2,F_NONE)}, exp_is: 4'b1111};
    vt[7] = '{g: {mk(4,6,1,0,F_BPU), mk(3,5,1,0,F_NONE), mk(2,4,1,0,F_NONE), mk(1,3,1,0,F_BPU)}, exp_is: 4'b0111};
    vt[8] = '{g: {mk(4,6,1,0,F_NONE), mk(3,5,1,4,F_NONE), mk(2,4,1,0,F_NONE), mk(1,3,1,0,F_NONE)}, exp_is: 4'b0011};
    vt[9] = '{g: {mk(4,6,1,0,F_NONE), mk(3,5,1,0,F_MUL), mk(2,4,1,0,F_DIV), mk(1,3,1,0,F_MUL)}, exp_is: 4'b0011};

    // ---------------- reset ----------------
    idle_all();
    rst = 1'b1;
    tick();
    chk("reset_ready_low_a", a_ready, 0);
    chk("reset_ready_low_b", b_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("reset_ready_a", a_ready, 1);
    chk("reset_is_a", a_is, 0);
    chk("reset_exv_a", a_exv, 0);
    chk("reset_ready_b", b_ready, 1);
    chk("reset_is_b", b_is, 0);

    // ---------------- table-driven vectors on ISSUE_W=4 ----------------
    for (int i = 0; i < 10; i++) begin
      b_inst = vt[i].g; b_valid = 4'hF;
      tick();
      b_valid = '0;
      #1;
      chk($sformatf("vec%0d_is", i), b_is, vt[i].exp_is);
      chk($sformatf("vec%0d_exv", i), b_exv, vt[i].exp_is[0]);
      chk($sformatf("vec%0d_lane0", i), b_exi[0], vt[i].g[0]);
      b_flush = 1'b1;
      #1;
      chk($sformatf("vec%0d_flush_is", i), b_is, 0);
      tick();
      b_flush = 1'b0;
    end

    // ---------------- ISSUE_W=2 RAW pair ----------------
    a_inst[0] = mk(1, 3, 1, 2, F_NONE); a_inst[1] = mk(2, 5, 3, 4, F_NONE); a_valid = 2'b11;
    tick();
    a_valid = '0;
    #1;
    chk("raw_pair_is0", a_is, 2'b01);
    chk("raw_pair_tag0", a_exi[0].tag, 1);
    a_exr = 1'b1;
    tick();
    #1;
    chk("raw_pair_is1", a_is, 2'b01);
    chk("raw_pair_tag1", a_exi[0].tag, 2);
    tick();
    a_exr = 1'b0;
    #1;
    chk("raw_pair_empty", a_is, 0);

    // ---------------- ISSUE_W=2 fill, full, wrap ----------------
    for (int g = 0; g < 4; g++) begin
      a_inst[0] = mk(101 + 2 * g, 0, 1, 0, F_NONE); a_inst[1] = mk(102 + 2 * g, 0, 1, 0, F_NONE);
      a_valid = (g == 3) ? 2'b01 : 2'b11;
      tick();
      a_valid = '0;
      #1;
      chk($sformatf("fill_ready_%0d", g), a_ready, (g == 3) ? 0 : 1);
      chk($sformatf("fill_stall_is_%0d", g), a_is, 2'b11);
    end
    a_exr = 1'b1;
    #1;
    for (int c = 0; c < 20 && got.size() < 7; c++) begin
      for (int k = 0; k < 2; k++) if (a_is[k]) got.push_back(int'(a_exi[k].tag));
      tick();
    end
    a_exr = 1'b0;
    #1;
    chk("drain_count", got.size(), 7);
    for (int i = 0; i < got.size(); i++) chk($sformatf("drain_order_%0d", i), got[i], 101 + i);
    chk("drain_ready", a_ready, 1);
    chk("drain_empty", a_is, 0);

    // ---------------- ISSUE_W=4 scoreboard stall and writeback ----------------
    b_inst = vt[0].g; b_valid = 4'hF;
    tick();
    b_valid = '0; b_exr = 1'b1;
    #1;
    chk("sb_group_is", b_is, 4'b1111);
    tick();
    b_exr = 1'b0;
    b_inst[0] = mk(20, 8, 7, 0, F_NONE); b_valid = 4'b0001;
    tick();
    b_valid = '0;
    #1;
    chk("sb_stall0", b_is, 0);
    tick();
    #1;
    chk("sb_stall1", b_is, 0);
    b_wbv = 2'b01; b_wbr[0] = 5'd7;
    #1;
    chk("sb_wb_same_cycle", b_is, BYP ? 4'b0001 : 4'b0000);
    tick();
    b_wbv = '0;
    #1;
    chk("sb_wb_next_cycle", b_is, 4'b0001);
    b_exr = 1'b1;
    tick();
    b_exr = 1'b0;

    // ---------------- set and clear of r4 in one cycle ----------------
    b_inst[0] = mk(30, 4, 1, 0, F_LSU); b_valid = 4'b0001;
    tick();
    b_valid = '0;
    #1;
    chk("sc_ld_is", b_is, 4'b0001);
    b_exr = 1'b1; b_wbv = 2'b10; b_wbr[1] = 5'd4;
    tick();
    b_exr = 1'b0; b_wbv = '0;
    b_inst[0] = mk(31, 6, 4, 0, F_NONE); b_valid = 4'b0001;
    tick();
    b_valid = '0;
    #1;
    chk("sc_busy0", b_is, 0);
    tick();
    #1;
    chk("sc_busy1", b_is, 0);
    b_wbv = 2'b01; b_wbr[0] = 5'd4;
    #1;
    chk("sc_wb_same_cycle", b_is, BYP ? 4'b0001 : 4'b0000);
    tick();
    b_wbv = '0;
    #1;
    chk("sc_wb_next_cycle", b_is, 4'b0001);
    b_exr = 1'b1;
    tick();
    b_exr = 1'b0;

    // ---------------- flush with 5 buffered and a same-cycle enqueue ----------------
    for (int k = 0; k < 4; k++) b_inst[k] = mk(40 + k, 0, 1, 0, F_NONE);
    b_valid = 4'hF;
    tick();
    b_inst[0] = mk(44, 0, 1, 0, F_NONE); b_valid = 4'b0001;
    tick();
    b_valid = '0;
    #1;
    chk("fl_pre_is", b_is, 4'b1111);
    chk("fl_pre_ready", b_ready, 0);
    b_flush = 1'b1; b_valid = 4'hF;
    #1;
    chk("fl_cycle_is", b_is, 0);
    chk("fl_cycle_exv", b_exv, 0);
    tick();
    b_flush = 1'b0; b_valid = '0;
    #1;
    chk("fl_after_is", b_is, 0);
    chk("fl_after_ready", b_ready, 1);
    b_valid = 4'hF;
    tick();
    #1;
    chk("fl_cnt4_ready", b_ready, 1);
    tick();
    b_valid = '0;
    #1;
    chk("fl_cnt8_ready", b_ready, 0);
    b_flush = 1'b1;
    tick();
    b_flush = 1'b0;
    b_inst[0] = mk(50, 11, 10, 0, F_NONE); b_valid = 4'b0001;
    tick();
    b_valid = '0;
    #1;
    chk("fl_busy_kept", b_is, 0);
    b_wbv = 2'b11; b_wbr[0] = 5'd9; b_wbr[1] = 5'd10;
    tick();
    b_wbv = '0;
    #1;
    chk("fl_busy_cleared", b_is, 4'b0001);
    b_exr = 1'b1;
    tick();
    b_exr = 1'b0;

    // ---------------- randomized run against the reference model ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq.delete();
    for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int         n;
      logic [3:0] exp_is;
      bit         exp_ready;
      bit         xfer;
      int         iss;
      if (cyc == 1000) begin
        idle_all();
        rst = 1'b1;
        #1;
        chk("rnd_midreset_ready", b_ready, 0);
        tick();
        rst = 1'b0;
        mq.delete();
        for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
      end
      n = $urandom_range(0, 4);
      b_valid = 4'((1 << n) - 1);
      for (int k = 0; k < 4; k++) b_inst[k] = rnd_inst(1000 + cyc * 4 + k);
      b_flush = ($urandom_range(0, 31) == 0);
      b_exr = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 2; p++) begin
        b_wbv[p] = ($urandom_range(0, 2) == 0);
        b_wbr[p] = 5'($urandom_range(0, 7));
      end
      #1;
      for (int r = 0; r < 32; r++) eff[r] = mbusy[r];
      if (BYP) for (int p = 0; p < 2; p++) if (b_wbv[p]) eff[b_wbr[p]] = 1'b0;
      exp_is = '0;
      if (!b_flush) begin
        for (int k = 0; k < 4 && k < mq.size(); k++) begin
          if (!can_issue(k)) break;
          exp_is[k] = 1'b1;
        end
      end
      exp_ready = (mq.size() <= 4);
      chk("rnd_is", b_is, exp_is);
      chk("rnd_exv", b_exv, exp_is[0]);
      chk("rnd_ready", b_ready, exp_ready);
      for (int k = 0; k < 4; k++) if (exp_is[k]) chk("rnd_inst", b_exi[k], mq[k]);
      // model update: writebacks clear, issued late writers set (set wins)
      xfer = exp_is[0] && b_exr;
      for (int p = 0; p < 2; p++) if (b_wbv[p]) mbusy[b_wbr[p]] = 1'b0;
      iss = 0;
      if (xfer) begin
        for (int k = 0; k < 4; k++) begin
          if (exp_is[k]) begin
            iss++;
            if ((mq[k].need_lsu || mq[k].need_mul || mq[k].need_div) && mq[k].w_reg != 0)
              mbusy[mq[k].w_reg] = 1'b1;
          end
        end
      end
      for (int k = 0; k < iss; k++) void'(mq.pop_front());
      if (b_flush) mq.delete();
      else if (exp_ready && b_valid[0]) for (int k = 0; k < n; k++) mq.push_back(b_inst[k]);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
